// File: rtl/id_ex_reg.sv
// ID/EX pipeline register for the 5-stage RV32 core.
// Detects load-use hazards, inserts bubbles on hazards and flushes, freezes on back-pressure.
module id_ex_reg #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [RA_W-1:0] id_rs1,
    input  logic [RA_W-1:0] id_rs2,
    input  logic [RA_W-1:0] id_rd,
    input  logic [1:0]      id_alu_op,
    input  logic            id_fun7,
    input  logic [2:0]      id_fun3,
    input  logic            id_alu_src,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic            id_reg_write,
    input  logic            id_mem_to_reg,
    input  logic            id_branch,

    input  logic            flush,
    input  logic            ex_hold,

    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [RA_W-1:0] ex_rs1,
    output logic [RA_W-1:0] ex_rs2,
    output logic [RA_W-1:0] ex_rd,
    output logic [1:0]      ex_alu_op,
    output logic            ex_fun7,
    output logic [2:0]      ex_fun3,
    output logic            ex_alu_src,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_reg_write,
    output logic            ex_mem_to_reg,
    output logic            ex_branch,

    output logic            stall,
    output logic [15:0]     bubble_cnt
);

    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_rs1_data;
    logic [XLEN-1:0] r_rs2_data;
    logic [XLEN-1:0] r_imm;
    logic [RA_W-1:0] r_rs1;
    logic [RA_W-1:0] r_rs2;
    logic [RA_W-1:0] r_rd;
    logic [1:0]      r_alu_op;
    logic            r_fun7;
    logic [2:0]      r_fun3;
    logic            r_alu_src;
    logic            r_mem_read;
    logic            r_mem_write;
    logic            r_reg_write;
    logic            r_mem_to_reg;
    logic            r_branch;
    logic [15:0]     r_bubble_cnt;

    logic            w_rd_nonzero;
    logic            w_rd_match;
    logic            w_load_use;
    logic            w_bubble;
    logic            w_capture;
    logic            w_cnt_sat;

    // rs2 is compared for every opcode; a spurious stall on an I-type is harmless.
    assign w_rd_nonzero = (r_rd != '0);
    assign w_rd_match   = (r_rd == id_rs1) | (r_rd == id_rs2);
    assign w_load_use   = id_valid & r_valid & r_mem_read & w_rd_nonzero & w_rd_match;

    assign stall        = (w_load_use & ~flush) | ex_hold;

    // Flush outranks hold; a hazard seen during hold waits until hold drops.
    assign w_bubble     = flush | (~ex_hold & w_load_use);
    assign w_capture    = ~flush & ~ex_hold & ~w_load_use;
    assign w_cnt_sat    = (r_bubble_cnt == 16'hFFFF);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid      <= 1'b0;
            r_pc         <= '0;
            r_rs1_data   <= '0;
            r_rs2_data   <= '0;
            r_imm        <= '0;
            r_rs1        <= '0;
            r_rs2        <= '0;
            r_rd         <= '0;
            r_alu_op     <= 2'b00;
            r_fun7       <= 1'b0;
            r_fun3       <= 3'b000;
            r_alu_src    <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_branch     <= 1'b0;
        end else if (w_bubble) begin
            // alu_op=00 with fun3/fun7 clear decodes as ADD downstream.
            r_valid      <= 1'b0;
            r_pc         <= '0;
            r_rs1_data   <= '0;
            r_rs2_data   <= '0;
            r_imm        <= '0;
            r_rs1        <= '0;
            r_rs2        <= '0;
            r_rd         <= '0;
            r_alu_op     <= 2'b00;
            r_fun7       <= 1'b0;
            r_fun3       <= 3'b000;
            r_alu_src    <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_branch     <= 1'b0;
        end else if (w_capture) begin
            // Fields load as-is even when id_valid is low; EX qualifies with ex_valid.
            r_valid      <= id_valid;
            r_pc         <= id_pc;
            r_rs1_data   <= id_rs1_data;
            r_rs2_data   <= id_rs2_data;
            r_imm        <= id_imm;
            r_rs1        <= id_rs1;
            r_rs2        <= id_rs2;
            r_rd         <= id_rd;
            r_alu_op     <= id_alu_op;
            r_fun7       <= id_fun7;
            r_fun3       <= id_fun3;
            r_alu_src    <= id_alu_src;
            r_mem_read   <= id_mem_read;
            r_mem_write  <= id_mem_write;
            r_reg_write  <= id_reg_write;
            r_mem_to_reg <= id_mem_to_reg;
            r_branch     <= id_branch;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bubble_cnt <= 16'h0000;
        end else if (w_bubble && !w_cnt_sat) begin
            r_bubble_cnt <= r_bubble_cnt + 16'h0001;
        end
    end

    assign ex_valid      = r_valid;
    assign ex_pc         = r_pc;
    assign ex_rs1_data   = r_rs1_data;
    assign ex_rs2_data   = r_rs2_data;
    assign ex_imm        = r_imm;
    assign ex_rs1        = r_rs1;
    assign ex_rs2        = r_rs2;
    assign ex_rd         = r_rd;
    assign ex_alu_op     = r_alu_op;
    assign ex_fun7       = r_fun7;
    assign ex_fun3       = r_fun3;
    assign ex_alu_src    = r_alu_src;
    assign ex_mem_read   = r_mem_read;
    assign ex_mem_write  = r_mem_write;
    assign ex_reg_write  = r_reg_write;
    assign ex_mem_to_reg = r_mem_to_reg;
    assign ex_branch     = r_branch;
    assign bubble_cnt    = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed bench for id_ex_reg: vector table for single-cycle behaviour plus
// hand sequences for hold, pending hazards, saturation and reset during hold.
module tb_id_ex_reg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [1:0]  alu_op;
        logic        fun7;
        logic [2:0]  fun3;
        logic        alu_src;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic        mem_to_reg;
        logic        branch;
    } fields_t;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [1:0]  op;
        logic        mr;
        logic        fl;
        logic        hd;
        logic        exp_stall;
        logic        exp_cap;
        logic        exp_valid;
        logic [15:0] exp_cnt;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [1:0]  id_alu_op;
    logic        id_fun7;
    logic [2:0]  id_fun3;
    logic        id_alu_src, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg, id_branch;
    logic        flush, ex_hold;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [1:0]  ex_alu_op;
    logic        ex_fun7;
    logic [2:0]  ex_fun3;
    logic        ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch;
    logic        stall;
    logic [15:0] bubble_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_cnt;
    vec_t vecs[13];

    id_ex_reg #(.XLEN(32), .RA_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
        .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_alu_op(id_alu_op), .id_fun7(id_fun7), .id_fun3(id_fun3),
        .id_alu_src(id_alu_src), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch),
        .flush(flush), .ex_hold(ex_hold),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_alu_op(ex_alu_op), .ex_fun7(ex_fun7), .ex_fun3(ex_fun3),
        .ex_alu_src(ex_alu_src), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch),
        .stall(stall), .bubble_cnt(bubble_cnt)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Build a full ID field set from a few key values; the rest derive from pc.
    function automatic fields_t mk(input logic [31:0] pc, input logic [4:0] rs1,
                                   input logic [4:0] rs2, input logic [4:0] rd,
                                   input logic [1:0] op, input logic mr);
        fields_t f;
        f.pc         = pc;
        f.rs1_data   = pc ^ 32'hDEAD_0000;
        f.rs2_data   = pc ^ 32'h0000_BEEF;
        f.imm        = ~pc;
        f.rs1        = rs1;
        f.rs2        = rs2;
        f.rd         = rd;
        f.alu_op     = op;
        f.fun7       = pc[2];
        f.fun3       = pc[5:3];
        f.alu_src    = op[0];
        f.mem_read   = mr;
        f.mem_write  = (op == 2'b00) & ~mr;
        f.reg_write  = (rd != 5'd0);
        f.mem_to_reg = mr;
        f.branch     = (op == 2'b01);
        return f;
    endfunction

    function automatic vec_t mkv(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [4:0] rd, input logic [1:0] op,
                                 input logic mr, input logic fl, input logic hd,
                                 input logic es, input logic ec, input logic ev,
                                 input logic [15:0] cnt);
        vec_t t;
        t.valid = v; t.pc = pc; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd; t.op = op; t.mr = mr;
        t.fl = fl; t.hd = hd; t.exp_stall = es; t.exp_cap = ec; t.exp_valid = ev; t.exp_cnt = cnt;
        return t;
    endfunction

    // driver tasks
    task automatic drive(input fields_t f, input logic v);
        id_valid      = v;
        id_pc         = f.pc;
        id_rs1_data   = f.rs1_data;
        id_rs2_data   = f.rs2_data;
        id_imm        = f.imm;
        id_rs1        = f.rs1;
        id_rs2        = f.rs2;
        id_rd         = f.rd;
        id_alu_op     = f.alu_op;
        id_fun7       = f.fun7;
        id_fun3       = f.fun3;
        id_alu_src    = f.alu_src;
        id_mem_read   = f.mem_read;
        id_mem_write  = f.mem_write;
        id_reg_write  = f.reg_write;
        id_mem_to_reg = f.mem_to_reg;
        id_branch     = f.branch;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_ex(input string tag, input fields_t e, input logic ev, input logic [15:0] ecnt);
        chk({tag, " ex_valid"},      {31'd0, ex_valid},      {31'd0, ev});
        chk({tag, " ex_pc"},         ex_pc,                  e.pc);
        chk({tag, " ex_rs1_data"},   ex_rs1_data,            e.rs1_data);
        chk({tag, " ex_rs2_data"},   ex_rs2_data,            e.rs2_data);
        chk({tag, " ex_imm"},        ex_imm,                 e.imm);
        chk({tag, " ex_rs1"},        {27'd0, ex_rs1},        {27'd0, e.rs1});
        chk({tag, " ex_rs2"},        {27'd0, ex_rs2},        {27'd0, e.rs2});
        chk({tag, " ex_rd"},         {27'd0, ex_rd},         {27'd0, e.rd});
        chk({tag, " ex_alu_op"},     {30'd0, ex_alu_op},     {30'd0, e.alu_op});
        chk({tag, " ex_fun7"},       {31'd0, ex_fun7},       {31'd0, e.fun7});
        chk({tag, " ex_fun3"},       {29'd0, ex_fun3},       {29'd0, e.fun3});
        chk({tag, " ex_alu_src"},    {31'd0, ex_alu_src},    {31'd0, e.alu_src});
        chk({tag, " ex_mem_read"},   {31'd0, ex_mem_read},   {31'd0, e.mem_read});
        chk({tag, " ex_mem_write"},  {31'd0, ex_mem_write},  {31'd0, e.mem_write});
        chk({tag, " ex_reg_write"},  {31'd0, ex_reg_write},  {31'd0, e.reg_write});
        chk({tag, " ex_mem_to_reg"}, {31'd0, ex_mem_to_reg}, {31'd0, e.mem_to_reg});
        chk({tag, " ex_branch"},     {31'd0, ex_branch},     {31'd0, e.branch});
        chk({tag, " bubble_cnt"},    {16'd0, bubble_cnt},    {16'd0, ecnt});
    endtask

    // Apply inputs just after an edge, check combinational stall, then advance one edge.
    task automatic step(input string tag, input fields_t f, input logic v,
                        input logic fl, input logic hd, input logic exp_stall);
        drive(f, v);
        flush   = fl;
        ex_hold = hd;
        #1;
        chk({tag, " stall"}, {31'd0, stall}, {31'd0, exp_stall});
        @(posedge clk);
        #1;
    endtask

    initial begin
        fields_t f;
        fields_t held;
        fields_t ones;
        fields_t zero;
        zero = '0;
        ones = '1;

        // lw x5 / add x6,x5,x7 / lw x0 / x0 reader / lw x9 / rs2 hazard / flush+hazard / id_valid=0 / flush
        vecs[0]  = mkv(1, 32'h100,  2, 3,  5, 2'b00, 1, 0, 0, 0, 1, 1, 16'd0);
        vecs[1]  = mkv(1, 32'h104,  5, 7,  6, 2'b10, 0, 0, 0, 1, 0, 0, 16'd1);
        vecs[2]  = mkv(1, 32'h104,  5, 7,  6, 2'b10, 0, 0, 0, 0, 1, 1, 16'd1);
        vecs[3]  = mkv(1, 32'h108,  1, 2,  0, 2'b00, 1, 0, 0, 0, 1, 1, 16'd1);
        vecs[4]  = mkv(1, 32'h10C,  0, 0,  3, 2'b11, 0, 0, 0, 0, 1, 1, 16'd1);
        vecs[5]  = mkv(1, 32'h110,  4, 4,  9, 2'b00, 1, 0, 0, 0, 1, 1, 16'd1);
        vecs[6]  = mkv(1, 32'h114,  8, 9,  0, 2'b00, 0, 0, 0, 1, 0, 0, 16'd2);
        vecs[7]  = mkv(1, 32'h114,  8, 9,  0, 2'b00, 0, 0, 0, 0, 1, 1, 16'd2);
        vecs[8]  = mkv(1, 32'h118,  1, 1, 12, 2'b00, 1, 0, 0, 0, 1, 1, 16'd2);
        vecs[9]  = mkv(1, 32'h11C, 12, 0, 13, 2'b10, 0, 1, 0, 0, 0, 0, 16'd3);
        vecs[10] = mkv(0, 32'h120,  1, 2, 14, 2'b11, 1, 0, 0, 0, 1, 0, 16'd3);
        vecs[11] = mkv(1, 32'h124, 14, 0, 15, 2'b10, 0, 0, 0, 0, 1, 1, 16'd3);
        vecs[12] = mkv(1, 32'h128,  1, 2, 16, 2'b10, 0, 1, 0, 0, 0, 0, 16'd4);

        // reset with every input driven high, including flush and hold
        rst_n = 1'b0;
        drive(ones, 1'b1);
        flush   = 1'b1;
        ex_hold = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_ex("reset", zero, 1'b0, 16'd0);

        // release: R-type with bit30 set
        rst_n = 1'b1;
        f = mk(32'h4, 0, 0, 1, 2'b10, 0);
        step("release", f, 1'b1, 1'b0, 1'b0, 1'b0);
        check_ex("release", f, 1'b1, 16'd0);

        for (int i = 0; i < 13; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            f = mk(vecs[i].pc, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].op, vecs[i].mr);
            step(tag, f, vecs[i].valid, vecs[i].fl, vecs[i].hd, vecs[i].exp_stall);
            check_ex(tag, vecs[i].exp_cap ? f : zero, vecs[i].exp_valid, vecs[i].exp_cnt);
        end
        exp_cnt = 16'd4;

        // hold for 3 cycles with changing ID, including a dependent reader of x7
        held = mk(32'h200, 1, 2, 7, 2'b00, 1);
        step("hold_ld", held, 1'b1, 1'b0, 1'b0, 1'b0);
        check_ex("hold_ld", held, 1'b1, exp_cnt);
        for (int i = 0; i < 3; i++) begin
            string tag;
            tag = $sformatf("hold%0d", i);
            f = mk(32'h300 + 32'(4 * i), 7, 7, 5'(8 + i), 2'b10, 0);
            step(tag, f, 1'b1, 1'b0, 1'b1, 1'b1);
            check_ex(tag, held, 1'b1, exp_cnt);
        end
        f = mk(32'h30C, 1, 2, 11, 2'b10, 0);
        step("hold_rel", f, 1'b1, 1'b0, 1'b0, 1'b0);
        check_ex("hold_rel", f, 1'b1, exp_cnt);

        // hazard pending during hold is acted on once hold drops
        held = mk(32'h400, 1, 2, 9, 2'b00, 1);
        step("pend_ld", held, 1'b1, 1'b0, 1'b0, 1'b0);
        check_ex("pend_ld", held, 1'b1, exp_cnt);
        f = mk(32'h404, 9, 3, 10, 2'b10, 0);
        step("pend_hold", f, 1'b1, 1'b0, 1'b1, 1'b1);
        check_ex("pend_hold", held, 1'b1, exp_cnt);
        exp_cnt = exp_cnt + 16'd1;
        step("pend_bub", f, 1'b1, 1'b0, 1'b0, 1'b1);
        check_ex("pend_bub", zero, 1'b0, exp_cnt);
        step("pend_cap", f, 1'b1, 1'b0, 1'b0, 1'b0);
        check_ex("pend_cap", f, 1'b1, exp_cnt);

        // flush outranks hold and counts
        f = mk(32'h410, 1, 2, 3, 2'b11, 0);
        exp_cnt = exp_cnt + 16'd1;
        step("flush_hold", f, 1'b1, 1'b1, 1'b1, 1'b1);
        check_ex("flush_hold", zero, 1'b0, exp_cnt);

        // saturation: 65535 flushes from a nonzero count, then one more
        f = mk(32'h420, 1, 2, 3, 2'b10, 0);
        drive(f, 1'b1);
        flush   = 1'b1;
        ex_hold = 1'b0;
        for (int i = 0; i < 65535; i++) begin
            @(posedge clk);
        end
        #1;
        chk("sat_reach bubble_cnt", {16'd0, bubble_cnt}, 32'h0000_FFFF);
        @(posedge clk);
        #1;
        check_ex("sat_extra", zero, 1'b0, 16'hFFFF);

        // reset while holding and flushing clears everything
        f = mk(32'h500, 1, 2, 4, 2'b11, 0);
        step("pre_rst", f, 1'b1, 1'b0, 1'b0, 1'b0);
        check_ex("pre_rst", f, 1'b1, 16'hFFFF);
        rst_n   = 1'b0;
        flush   = 1'b1;
        ex_hold = 1'b1;
        @(posedge clk);
        #1;
        check_ex("rst_hold", zero, 1'b0, 16'd0);
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
